aib_mac_rx_chk: RTL and testbench
=================================

// Module: aib_mac_rx_chk
// PURPOSE
//  MAC-side receive data checker; consumes one channel's rx data (DWIDTH*2 bits/word) from the AIB adapter.
//  Locks onto an incrementing-counter pattern sent by the far-side MAC generator, then counts matched/mismatched words.
//  Qualified by the channel's rx_transfer_en and rx_align_done; one instance per channel in the MAC test harness.
// PARAMETERS
//  DWIDTH    40  per-channel half-word width; checked word DW = 2*DWIDTH bits (localparam DW)
//  LOCK_CNT  8   consecutive in-sequence valid words needed to lock (>=2)
//  LOSS_CNT  4   consecutive mismatches in LOCKED that drop lock (>=1)
//  CNT_W     16  width of word/error counters
// PORTS
//  rd_clk          in   1      read-side clock; all logic in this domain
//  rd_rstn         in   1      asynchronous active-low reset
//  rx_transfer_en  in   1      channel transfer enable
//  rx_align_done   in   1      word alignment complete
//  data_vld        in   1      data_in holds a word this cycle
//  data_in         in   DW     received word
//  clr_cnt         in   1      sync clear of counters and capture regs
//  chk_state       out  2      00 IDLE, 01 SEARCH, 10 LOCKED
//  locked          out  1      chk_state==LOCKED
//  err_pulse       out  1      1-cycle pulse, cycle after a mismatched word in LOCKED
//  word_cnt        out  CNT_W  matched words in LOCKED, saturating
//  err_cnt         out  CNT_W  mismatched words in LOCKED, saturating
//  first_err_vld   out  1      capture regs valid (macro only, else tied 0)
//  first_err_exp   out  DW     expected value of first mismatch (macro only, else 0)
//  first_err_act   out  DW     received value of first mismatch (macro only, else 0)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal run/miss counters 0, exp/prev regs 0.
//  - en = rx_transfer_en & rx_align_done (used directly, no sync). en low in any state -> IDLE next cycle; counters hold.
//  - IDLE: en high -> SEARCH next cycle, run_cnt=0. Words in IDLE ignored.
//  - data_vld low: no state, counter or exp change in any state.
//  - SEARCH, valid word: run_cnt==0 or data_in==prev+1 -> run_cnt++; else run_cnt=1. prev<=data_in.
//    When the increment makes run_cnt==LOCK_CNT: -> LOCKED, exp<=data_in+1, miss=0. locked high cycle after that word.
//  - LOCKED, valid word: data_in==exp -> word_cnt++ (sat), miss=0; else err_cnt++ (sat), miss++, err_pulse next cycle.
//    exp<=exp+1 on every valid word (no resync on error). miss reaches LOSS_CNT -> SEARCH, run_cnt=0, locked low next cycle.
//  - Arithmetic: +1 is modulo 2^DW; all-ones followed by 0 is in-sequence (no error).
//  - Counters saturate at 2^CNT_W-1 and hold; no wrap.
//  - clr_cnt: word_cnt, err_cnt, capture regs ->0 next cycle; priority over a coincident count/capture; FSM unaffected.
//  - Latency: data_in -> counters/err_pulse/capture = 1 cycle registered.
// CONFIGURATION
//  AIB_MAC_CHK_ERR_CAPTURE_EN defined: on first mismatch in LOCKED while first_err_vld==0, capture exp/data_in,
//    set first_err_vld; held until clr_cnt or reset (later errors do not overwrite).
//  Undefined: first_err_* tied to 0, no capture registers instantiated.
// TESTING
//  1 Reset asserted mid-run, data toggling -> all outputs 0, chk_state=00 while rd_rstn low.
//  2 en=1, words 0x100..0x107 back-to-back -> locked high cycle after 0x107; then 0x108..0x16B -> word_cnt=100, err_cnt=0.
//  3 Locked, send 0x200,0xDEAD,0x202 (exp 0x200 first) -> err_cnt=1, err_pulse 1 cycle, locked stays, word_cnt+2;
//    with macro: first_err_exp=0x201, first_err_act=0xDEAD, first_err_vld=1.
//  4 Locked, 4 consecutive bad words -> err_cnt=4, state SEARCH; then 8 in-sequence words -> LOCKED again.
//  5 DWIDTH=4 (DW=8): stream 0xF8..0x07 with gaps in data_vld -> locks, no errors across 0xFF->0x00 wrap.
//  6 rx_align_done drop in LOCKED -> IDLE next cycle, counts held; clr_cnt same cycle as mismatch -> err_cnt=0, vld=0.

Source files
------------

// File: rtl/aib_mac_rx_chk.sv
// MAC-side receive checker: locks onto an incrementing-counter stream and counts matched/mismatched words.
// Define AIB_MAC_CHK_ERR_CAPTURE_EN to keep the expected/received values of the first mismatch.
module aib_mac_rx_chk #(
    parameter int DWIDTH   = 40,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  rx_transfer_en,
    input  logic                  rx_align_done,
    input  logic                  data_vld,
    input  logic [2*DWIDTH-1:0]   data_in,
    input  logic                  clr_cnt,
    output logic [1:0]            chk_state,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  first_err_vld,
    output logic [2*DWIDTH-1:0]   first_err_exp,
    output logic [2*DWIDTH-1:0]   first_err_act
);

    localparam int DW = 2 * DWIDTH;
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [RW-1:0] LOCK_V = RW'(LOCK_CNT);
    localparam logic [MW-1:0] LOSS_V = MW'(LOSS_CNT);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SEARCH = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    run_q, run_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [DW-1:0]    prev_q, prev_d;
    logic [DW-1:0]    exp_q, exp_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             en;

    assign en = rx_transfer_en & rx_align_done;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        miss_d  = miss_q;
        prev_d  = prev_q;
        exp_d   = exp_q;
        word_d  = word_q;
        err_d   = err_q;
        pulse_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    run_d   = '0;
                end
                SEARCH: begin
                    if (data_vld) begin
                        prev_d = data_in;
                        // The first word of a run is always accepted; a break restarts the run at this word.
                        if (run_q == '0 || data_in == prev_q + DW'(1)) begin
                            run_d = run_q + RW'(1);
                        end else begin
                            run_d = RW'(1);
                        end
                        if (run_d == LOCK_V) begin
                            state_d = LOCKED;
                            exp_d   = data_in + DW'(1);
                            miss_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (data_vld) begin
                        exp_d = exp_q + DW'(1);
                        if (data_in == exp_q) begin
                            if (word_q != '1) word_d = word_q + CNT_W'(1);
                            miss_d = '0;
                        end else begin
                            if (err_q != '1) err_d = err_q + CNT_W'(1);
                            pulse_d = 1'b1;
                            miss_d  = miss_q + MW'(1);
                            if (miss_d == LOSS_V) begin
                                state_d = SEARCH;
                                run_d   = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (clr_cnt) begin
            word_d = '0;
            err_d  = '0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state_q <= IDLE;
            run_q   <= '0;
            miss_q  <= '0;
            prev_q  <= '0;
            exp_q   <= '0;
            word_q  <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            prev_q  <= prev_d;
            exp_q   <= exp_d;
            word_q  <= word_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

    assign chk_state = state_q;
    assign locked    = (state_q == LOCKED);
    assign err_pulse = pulse_q;
    assign word_cnt  = word_q;
    assign err_cnt   = err_q;

`ifdef AIB_MAC_CHK_ERR_CAPTURE_EN
    logic          cap_hit;
    logic          fvld_q;
    logic [DW-1:0] fexp_q;
    logic [DW-1:0] fact_q;

    assign cap_hit = en && (state_q == LOCKED) && data_vld && (data_in != exp_q);

    // Only the first mismatch after reset/clear is kept; clear wins over a coincident capture.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            fvld_q <= 1'b0;
            fexp_q <= '0;
            fact_q <= '0;
        end else if (clr_cnt) begin
            fvld_q <= 1'b0;
            fexp_q <= '0;
            fact_q <= '0;
        end else if (cap_hit && !fvld_q) begin
            fvld_q <= 1'b1;
            fexp_q <= exp_q;
            fact_q <= data_in;
        end
    end

    assign first_err_vld = fvld_q;
    assign first_err_exp = fexp_q;
    assign first_err_act = fact_q;
`else
    assign first_err_vld = 1'b0;
    assign first_err_exp = '0;
    assign first_err_act = '0;
`endif

endmodule

// File: tb/tb_aib_mac_rx_chk.sv
// Directed bench for aib_mac_rx_chk: a default-width instance plus a narrow instance for wrap and saturation.
module tb_aib_mac_rx_chk;

  logic        clk;
  logic        rstn;
  logic        te;
  logic        ad;
  logic        vld;
  logic [79:0] din;
  logic        clr;
  logic [1:0]  chk_state;
  logic        locked;
  logic        err_pulse;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;
  logic        fvld;
  logic [79:0] fexp;
  logic [79:0] fact;

  logic        n_en;
  logic        n_vld;
  logic [7:0]  n_din;
  logic        n_clr;
  logic [1:0]  n_state;
  logic        n_locked;
  logic        n_pulse;
  logic [2:0]  n_word_cnt;
  logic [2:0]  n_err_cnt;
  logic        n_fvld;
  logic [7:0]  n_fexp;
  logic [7:0]  n_fact;

  int n_cmp = 0;
  int n_bad = 0;

  aib_mac_rx_chk dut (
    .rd_clk(clk), .rd_rstn(rstn), .rx_transfer_en(te), .rx_align_done(ad),
    .data_vld(vld), .data_in(din), .clr_cnt(clr),
    .chk_state(chk_state), .locked(locked), .err_pulse(err_pulse),
    .word_cnt(word_cnt), .err_cnt(err_cnt),
    .first_err_vld(fvld), .first_err_exp(fexp), .first_err_act(fact)
  );

  aib_mac_rx_chk #(.DWIDTH(4), .LOCK_CNT(8), .LOSS_CNT(12), .CNT_W(3)) dut_n (
    .rd_clk(clk), .rd_rstn(rstn), .rx_transfer_en(n_en), .rx_align_done(n_en),
    .data_vld(n_vld), .data_in(n_din), .clr_cnt(n_clr),
    .chk_state(n_state), .locked(n_locked), .err_pulse(n_pulse),
    .word_cnt(n_word_cnt), .err_cnt(n_err_cnt),
    .first_err_vld(n_fvld), .first_err_exp(n_fexp), .first_err_act(n_fact)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [79:0] d);
    vld = 1'b1;
    din = d;
    tick();
  endtask

  task automatic idle();
    vld = 1'b0;
    tick();
  endtask

  initial begin
    rstn  = 1'b0;
    te    = 1'b1;
    ad    = 1'b1;
    vld   = 1'b1;
    din   = '0;
    clr   = 1'b0;
    n_en  = 1'b1;
    n_vld = 1'b0;
    n_din = '0;
    n_clr = 1'b0;

    // reset held with data toggling
    repeat (3) begin
      din = 80'($urandom);
      tick();
    end
    check_val("rst_state", 128'(chk_state), 128'(0));
    check_val("rst_locked", 128'(locked), 128'(0));
    check_val("rst_pulse", 128'(err_pulse), 128'(0));
    check_val("rst_word_cnt", 128'(word_cnt), 128'(0));
    check_val("rst_err_cnt", 128'(err_cnt), 128'(0));
    check_val("rst_fvld", 128'(fvld), 128'(0));
    check_val("rst_fexp", 128'(fexp), 128'(0));

    rstn = 1'b1;
    idle();
    check_val("idle_to_search", 128'(chk_state), 128'(1));
    check_val("n_search", 128'(n_state), 128'(1));

    // lock on 0x100..0x107, then 100 in-sequence words
    for (int i = 0; i < 8; i++) begin
      send(80'(32'h100 + i));
      if (i == 6) check_val("pre_lock", 128'(locked), 128'(0));
    end
    check_val("lock_locked", 128'(locked), 128'(1));
    check_val("lock_state", 128'(chk_state), 128'(2));
    for (int i = 32'h108; i <= 32'h16B; i++) send(80'(i));
    check_val("t2_word_cnt", 128'(word_cnt), 128'(100));
    check_val("t2_err_cnt", 128'(err_cnt), 128'(0));

    // single mismatch in LOCKED
    for (int i = 32'h16C; i <= 32'h1FF; i++) send(80'(i));
    send(80'(32'h200));
    send(80'(32'hDEAD));
    check_val("t3_pulse_hi", 128'(err_pulse), 128'(1));
    check_val("t3_err_cnt", 128'(err_cnt), 128'(1));
    send(80'(32'h202));
    check_val("t3_pulse_lo", 128'(err_pulse), 128'(0));
    check_val("t3_locked", 128'(locked), 128'(1));
    check_val("t3_word_cnt", 128'(word_cnt), 128'(250));
`ifdef AIB_MAC_CHK_ERR_CAPTURE_EN
    check_val("t3_fvld", 128'(fvld), 128'(1));
    check_val("t3_fexp", 128'(fexp), 128'(32'h201));
    check_val("t3_fact", 128'(fact), 128'(32'hDEAD));
`else
    check_val("t3_fvld_off", 128'(fvld), 128'(0));
    check_val("t3_fact_off", 128'(fact), 128'(0));
`endif

    // clear, then four bad words drop lock
    vld = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_word_cnt", 128'(word_cnt), 128'(0));
    check_val("clr_err_cnt", 128'(err_cnt), 128'(0));
    check_val("clr_fvld", 128'(fvld), 128'(0));
    check_val("clr_locked", 128'(locked), 128'(1));
    for (int i = 0; i < 4; i++) begin
      send(80'(32'h5000 + i));
      if (i == 2) check_val("t4_still_locked", 128'(chk_state), 128'(2));
    end
    check_val("t4_err_cnt", 128'(err_cnt), 128'(4));
    check_val("t4_state", 128'(chk_state), 128'(1));
    check_val("t4_locked", 128'(locked), 128'(0));
`ifdef AIB_MAC_CHK_ERR_CAPTURE_EN
    check_val("t4_fexp", 128'(fexp), 128'(32'h203));
    check_val("t4_fact", 128'(fact), 128'(32'h5000));
`endif
    for (int i = 0; i < 8; i++) begin
      send(80'(32'h300 + i));
      if (i == 6) check_val("t4_relock_pre", 128'(chk_state), 128'(1));
    end
    check_val("t4_relock", 128'(chk_state), 128'(2));

    // align drop in LOCKED, then clear coincident with a mismatch
    send(80'(32'h308));
    send(80'(32'h309));
    check_val("t6_word_cnt", 128'(word_cnt), 128'(2));
    ad = 1'b0;
    send(80'(32'h30A));
    check_val("t6_idle", 128'(chk_state), 128'(0));
    check_val("t6_word_hold", 128'(word_cnt), 128'(2));
    check_val("t6_err_hold", 128'(err_cnt), 128'(4));
    ad = 1'b1;
    idle();
    check_val("t6_search", 128'(chk_state), 128'(1));
    for (int i = 0; i < 8; i++) send(80'(32'h400 + i));
    check_val("t6_relock", 128'(locked), 128'(1));
    clr = 1'b1;
    send(80'(32'h999));
    clr = 1'b0;
    check_val("t6_clr_err_cnt", 128'(err_cnt), 128'(0));
    check_val("t6_clr_fvld", 128'(fvld), 128'(0));
    send(80'(32'h998));
    check_val("t6_err_after", 128'(err_cnt), 128'(1));
    check_val("t6_pulse", 128'(err_pulse), 128'(1));
`ifdef AIB_MAC_CHK_ERR_CAPTURE_EN
    check_val("t6_fvld", 128'(fvld), 128'(1));
    check_val("t6_fexp", 128'(fexp), 128'(32'h409));
    check_val("t6_fact", 128'(fact), 128'(32'h998));
`endif
    vld = 1'b0;

    // narrow instance: 0xF8..0x07 with gaps, wrap and saturation
    for (int i = 0; i < 16; i++) begin
      n_vld = 1'b1;
      n_din = 8'(248 + i);
      tick();
      if (i == 6) check_val("n_pre_lock", 128'(n_locked), 128'(0));
      if (i == 7) check_val("n_lock", 128'(n_locked), 128'(1));
      n_vld = 1'b0;
      n_din = 8'($urandom);
      tick();
    end
    check_val("n_locked_wrap", 128'(n_locked), 128'(1));
    check_val("n_err_wrap", 128'(n_err_cnt), 128'(0));
    check_val("n_word_sat", 128'(n_word_cnt), 128'(7));
    for (int i = 0; i < 9; i++) begin
      n_vld = 1'b1;
      n_din = 8'(128 + i);
      tick();
    end
    n_vld = 1'b0;
    check_val("n_err_sat", 128'(n_err_cnt), 128'(7));
    check_val("n_locked_errs", 128'(n_locked), 128'(1));
    check_val("n_pulse", 128'(n_pulse), 128'(1));

    // reset asserted mid-run while locked with data toggling
    send(80'(32'h40B));
    check_val("pre_rst_locked", 128'(locked), 128'(1));
    rstn = 1'b0;
    #1;
    check_val("mid_rst_state", 128'(chk_state), 128'(0));
    check_val("mid_rst_word", 128'(word_cnt), 128'(0));
    check_val("mid_rst_fvld", 128'(fvld), 128'(0));
    check_val("mid_rst_n_locked", 128'(n_locked), 128'(0));
    check_val("mid_rst_n_word", 128'(n_word_cnt), 128'(0));
    repeat (2) send(80'($urandom));
    check_val("mid_rst_state2", 128'(chk_state), 128'(0));
    check_val("mid_rst_err", 128'(err_cnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
